// File: rtl/vga_timing_gen_pkg.sv
// vga_params: shared 640x480@60 raster constants, derived totals and sync
// window bounds, the colour constants used by the pixel controllers, and
// a width helper.
package vga_params;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  typedef logic [11:0] rgb_t;
  localparam rgb_t COL_BLACK  = 12'h000;
  localparam rgb_t COL_WHITE  = 12'hFFF;
  localparam rgb_t COL_BLUE   = 12'h00F;
  localparam rgb_t COL_YELLOW = 12'hFF0;
  localparam rgb_t COL_RED    = 12'hF00;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel controllers.
//   master: driven by the timing generator
//   slave : consumed by sprite/bonus/maze controllers
interface vga_timing_gen_if;
  import vga_params::*;

  logic               pixel_en;
  logic [H_CNT_W-1:0] h_counter;
  logic [V_CNT_W-1:0] v_counter;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               frame_start;
  logic               vblank_start;
  logic               one_hz_enable;

  modport master (
    output pixel_en, h_counter, v_counter, hsync, vsync, video_on,
           frame_start, vblank_start, one_hz_enable
  );

  modport slave (
    input  pixel_en, h_counter, v_counter, hsync, vsync, video_on,
           frame_start, vblank_start, one_hz_enable
  );
endinterface

// File: rtl/vga_timing_gen_pixel_tick.sv
// pixel_tick: divides clk by CLK_DIV into a one-clk pixel_en tick.
//   clk, reset (sync, active-high) in; pixel_en out.
// pixel_en is registered: it is high in the cycle after div_cnt hits
// CLK_DIV-1. With CLK_DIV = 1 the counter sits at 0 and pixel_en is held
// high from the first edge after reset release.
module pixel_tick
  import vga_params::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_en
);
  localparam int DW = clog2_min1(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          div_last;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      pixel_en <= 1'b0;
    end else begin
      pixel_en <= div_last;
      div_cnt  <= div_last ? '0 : div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing plus frame-rate game pulses.
//   clk   in  system clock
//   reset in  synchronous, active-high
//   vga   master modport: pixel_en, h_counter, v_counter, hsync, vsync,
//         video_on, frame_start, vblank_start, one_hz_enable
// Sync/video decode and the frame pulses are registered from next-state
// counters so they line up with the counter values in the same cycle.
module vga_timing_gen
  import vga_params::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int H_VISIBLE      = VGA_H_VISIBLE,
  parameter int H_FRONT        = VGA_H_FRONT,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BACK         = VGA_H_BACK,
  parameter int V_VISIBLE      = VGA_V_VISIBLE,
  parameter int V_FRONT        = VGA_V_FRONT,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BACK         = VGA_V_BACK,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC;
  localparam int FW      = clog2_min1(FRAMES_PER_SEC);

  if (H_TOTAL > 2048) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 11-bit h_counter");
  end
  if (V_TOTAL > 1024) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 10-bit v_counter");
  end
  if (CLK_DIV < 1 || FRAMES_PER_SEC < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV and FRAMES_PER_SEC must be >= 1");
  end

  logic               pixel_en;
  logic [H_CNT_W-1:0] h_q, h_nxt;
  logic [V_CNT_W-1:0] v_q, v_nxt;
  logic [FW-1:0]      frame_cnt;
  logic               h_end, v_end;
  logic               frame_wrap, vblank_evt;
  logic               hsync_q, vsync_q, video_q;
  logic               frame_q, vblank_q, one_hz_q;

  pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .pixel_en (pixel_en)
  );

  assign h_end      = (h_q == H_CNT_W'(H_TOTAL - 1));
  assign v_end      = (v_q == V_CNT_W'(V_TOTAL - 1));
  // Events detected on the last pixel so the pulse lands with the new counters.
  assign frame_wrap = pixel_en & h_end & v_end;
  assign vblank_evt = pixel_en & h_end & (v_q == V_CNT_W'(V_VISIBLE - 1));

  always_comb begin
    h_nxt = h_q;
    v_nxt = v_q;
    if (pixel_en) begin
      if (h_end) begin
        h_nxt = '0;
        v_nxt = v_end ? '0 : v_q + 1'b1;
      end else begin
        h_nxt = h_q + 1'b1;
      end
    end
  end

  function automatic logic in_win(int x, int lo, int hi);
    return (x >= lo) && (x < hi);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q       <= '0;
      v_q       <= '0;
      frame_cnt <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      video_q   <= 1'b1;
      frame_q   <= 1'b0;
      vblank_q  <= 1'b0;
      one_hz_q  <= 1'b0;
    end else begin
      h_q      <= h_nxt;
      v_q      <= v_nxt;
      hsync_q  <= in_win(int'(h_nxt), HS_LO, HS_HI) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q  <= in_win(int'(v_nxt), VS_LO, VS_HI) ? VSYNC_POL : ~VSYNC_POL;
      video_q  <= (int'(h_nxt) < H_VISIBLE) && (int'(v_nxt) < V_VISIBLE);
      frame_q  <= frame_wrap;
      vblank_q <= vblank_evt;
      one_hz_q <= 1'b0;
      if (frame_wrap) begin
        if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
          frame_cnt <= '0;
          one_hz_q  <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign vga.pixel_en      = pixel_en;
  assign vga.h_counter     = h_q;
  assign vga.v_counter     = v_q;
  assign vga.hsync         = hsync_q;
  assign vga.vsync         = vsync_q;
  assign vga.video_on      = video_q;
  assign vga.frame_start   = frame_q;
  assign vga.vblank_start  = vblank_q;
  assign vga.one_hz_enable = one_hz_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: three generators (default 25 MHz, default timing at CLK_DIV=1,
// shrunken timing with FRAMES_PER_SEC=3) checked every cycle against an
// arithmetic model driven only by the count of edges since reset release.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pe;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, vo, fs, vb, oh;
  } obs_t;

  typedef struct {
    int d, hv, hf, hw, hb, vv, vf, vw, vbk, fps;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    int   e;
    logic pe;
    int   h, v;
    logic hs, vo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ab, rst_c;
  always #5 clk = ~clk;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();
  vga_timing_gen_if c_if ();

  vga_timing_gen #(.CLK_DIV(2)) u_a (.clk(clk), .reset(rst_ab), .vga(a_if));
  vga_timing_gen #(.CLK_DIV(1)) u_b (.clk(clk), .reset(rst_ab), .vga(b_if));
  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .FRAMES_PER_SEC(3)
  ) u_c (.clk(clk), .reset(rst_c), .vga(c_if));

  int   tests = 0, fails = 0;
  int   e_a = 0, e_c = 0;
  cfg_t cfg_a, cfg_b, cfg_c;

  // Position follows from how many pixel ticks have elapsed since release.
  function automatic obs_t model(cfg_t c, int e);
    int ht, vt, adv, prv, p, h, v;
    obs_t o;
    ht  = c.hv + c.hf + c.hw + c.hb;
    vt  = c.vv + c.vf + c.vw + c.vbk;
    adv = (e >= 1) ? (e - 1) / c.d : 0;
    prv = (e >= 2) ? (e - 2) / c.d : 0;
    p   = adv % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    o.pe = (e >= 1) && (e % c.d == 0);
    o.h  = 11'(h);
    o.v  = 10'(v);
    o.hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hw) ? c.hp : ~c.hp;
    o.vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vw) ? c.vp : ~c.vp;
    o.vo = (h < c.hv) && (v < c.vv);
    o.fs = (adv != prv) && (p == 0);
    o.vb = (adv != prv) && (p == c.vv * ht);
    o.oh = o.fs && ((adv / (ht * vt)) % c.fps == 0);
    return o;
  endfunction

  task automatic cmp_obs(string nm, int e, obs_t got, obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s e=%0d got pe=%b h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b vb=%b oh=%b want pe=%b h=%0d v=%0d hs=%b vs=%b vo=%b fs=%b vb=%b oh=%b",
               nm, e, got.pe, got.h, got.v, got.hs, got.vs, got.vo, got.fs, got.vb, got.oh,
               exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.fs, exp.vb, exp.oh);
    end
  endtask

  task automatic cmp_int(string nm, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic check_all();
    obs_t g;
    g = '{a_if.pixel_en, a_if.h_counter, a_if.v_counter, a_if.hsync, a_if.vsync,
          a_if.video_on, a_if.frame_start, a_if.vblank_start, a_if.one_hz_enable};
    cmp_obs("model_a", e_a, g, model(cfg_a, e_a));
    g = '{b_if.pixel_en, b_if.h_counter, b_if.v_counter, b_if.hsync, b_if.vsync,
          b_if.video_on, b_if.frame_start, b_if.vblank_start, b_if.one_hz_enable};
    cmp_obs("model_b", e_a, g, model(cfg_b, e_a));
    g = '{c_if.pixel_en, c_if.h_counter, c_if.v_counter, c_if.hsync, c_if.vsync,
          c_if.video_on, c_if.frame_start, c_if.vblank_start, c_if.one_hz_enable};
    cmp_obs("model_c", e_c, g, model(cfg_c, e_c));
  endtask

  // One clock edge; inputs only change between edges, outputs sampled 1ns after.
  task automatic tick();
    @(posedge clk);
    e_a = rst_ab ? 0 : e_a + 1;
    e_c = rst_c  ? 0 : e_c + 1;
    #1;
    check_all();
  endtask

  initial begin
    vec_t tab[10];
    int   first_fs, n_fs, first_oh, n_oh, first_vb, n_vb, oh_alone, oh_wide;
    int   prev_oh, cnt_hs, cnt_pe, wait_oh;

    cfg_a = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 60, 1'b0, 1'b0};
    cfg_b = cfg_a;
    cfg_b.d = 1;
    cfg_c = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 3, 1'b0, 1'b1};

    // Default generator after release: {edge, pixel_en, h, v, hsync, video_on}
    tab[0] = '{1,    1'b0, 0,   0, 1'b1, 1'b1};
    tab[1] = '{2,    1'b1, 0,   0, 1'b1, 1'b1};
    tab[2] = '{3,    1'b0, 1,   0, 1'b1, 1'b1};
    tab[3] = '{1281, 1'b0, 640, 0, 1'b1, 1'b0};
    tab[4] = '{1313, 1'b0, 656, 0, 1'b0, 1'b0};
    tab[5] = '{1503, 1'b0, 751, 0, 1'b0, 1'b0};
    tab[6] = '{1505, 1'b0, 752, 0, 1'b1, 1'b0};
    tab[7] = '{1599, 1'b0, 799, 0, 1'b1, 1'b0};
    tab[8] = '{1600, 1'b1, 799, 0, 1'b1, 1'b0};
    tab[9] = '{1601, 1'b0, 0,   1, 1'b1, 1'b1};

    rst_ab = 1'b1;
    rst_c  = 1'b1;
    repeat (3) tick();
    rst_ab = 1'b0;
    rst_c  = 1'b0;

    for (int i = 0; i < 10; i++) begin
      while (e_a < tab[i].e) tick();
      cmp_int($sformatf("tab%0d_pe", i), int'(a_if.pixel_en), int'(tab[i].pe));
      cmp_int($sformatf("tab%0d_h", i), int'(a_if.h_counter), tab[i].h);
      cmp_int($sformatf("tab%0d_v", i), int'(a_if.v_counter), tab[i].v);
      cmp_int($sformatf("tab%0d_hs", i), int'(a_if.hsync), int'(tab[i].hs));
      cmp_int($sformatf("tab%0d_vo", i), int'(a_if.video_on), int'(tab[i].vo));
    end

    // Frame pulses on the reduced generator: 98 clks/frame, 294 per one_hz.
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    first_fs = -1; first_oh = -1; first_vb = -1;
    n_fs = 0; n_oh = 0; n_vb = 0; oh_alone = 0; oh_wide = 0; prev_oh = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (c_if.frame_start) begin
        n_fs++;
        if (first_fs < 0) first_fs = e_c;
      end
      if (c_if.vblank_start) begin
        n_vb++;
        if (first_vb < 0) first_vb = e_c;
      end
      if (c_if.one_hz_enable) begin
        n_oh++;
        if (first_oh < 0) first_oh = e_c;
        if (!c_if.frame_start) oh_alone++;
        if (prev_oh != 0) oh_wide++;
      end
      prev_oh = int'(c_if.one_hz_enable);
    end
    cmp_int("first_frame_start", first_fs, 99);
    cmp_int("frame_start_count", n_fs, 7);
    cmp_int("first_vblank", first_vb, 57);
    cmp_int("vblank_count", n_vb, 7);
    cmp_int("first_one_hz", first_oh, 295);
    cmp_int("one_hz_count", n_oh, 2);
    cmp_int("one_hz_without_fs", oh_alone, 0);
    cmp_int("one_hz_wide", oh_wide, 0);

    // Reset mid-frame, one frame in so frame_cnt is non-zero.
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    while (e_c < 150) tick();
    cmp_int("pre_rst_h", int'(c_if.h_counter), 9);
    cmp_int("pre_rst_v", int'(c_if.v_counter), 3);
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;
    cmp_int("rst_h", int'(c_if.h_counter), 0);
    cmp_int("rst_v", int'(c_if.v_counter), 0);
    cmp_int("rst_hsync", int'(c_if.hsync), 1);
    cmp_int("rst_vsync", int'(c_if.vsync), 0);
    cmp_int("rst_pulses", int'({c_if.frame_start, c_if.one_hz_enable, c_if.pixel_en}), 0);
    wait_oh = -1;
    for (int i = 0; i < 1000 && wait_oh < 0; i++) begin
      tick();
      if (c_if.one_hz_enable) wait_oh = e_c;
    end
    cmp_int("one_hz_after_rst", wait_oh, 295);

    // CLK_DIV = 1 at default timing: one line, hsync 96 clks, pixel_en solid.
    rst_ab = 1'b1;
    tick();
    rst_ab = 1'b0;
    cnt_hs = 0;
    cnt_pe = 0;
    for (int i = 0; i < 801; i++) begin
      tick();
      if (!b_if.hsync) cnt_hs++;
      if (b_if.pixel_en) cnt_pe++;
    end
    cmp_int("b_hsync_width", cnt_hs, 96);
    cmp_int("b_pixel_en_high", cnt_pe, 801);

    // Random run lengths and reset pulses; the per-cycle model checks all.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 400)) tick();
      case ($urandom_range(0, 2))
        0: rst_c = 1'b1;
        1: rst_ab = 1'b1;
        default: begin rst_c = 1'b1; rst_ab = 1'b1; end
      endcase
      repeat ($urandom_range(1, 3)) tick();
      rst_ab = 1'b0;
      rst_c  = 1'b0;
    end
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
